// File: rtl/hilo_md_ctrl.sv
// hilo_md_ctrl: multiply/divide sequencer and HI/LO register owner (E stage).
// Arithmetic is computed in the issue cycle and parked in pending regs.
// A down-counter models the unit latency before the result reaches HI/LO.
module hilo_md_ctrl #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  E_MDOp,
    input  logic        E_Start,
    input  logic [31:0] E_A,
    input  logic [31:0] E_B,
    input  logic        E_MFSel,
    output logic [31:0] E_MDOut,
    output logic        E_HILObusy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] phi_q, phi_d;
    logic [31:0] plo_q, plo_d;
    logic        pval_q, pval_d;

    logic [63:0] prod_s, prod_u;
    logic        sdiv, neg_a, neg_b;
    logic [31:0] div_n, div_d, uq, ur, quo, rem;
    logic        is_md_op;

    // Datapath: products and a single shared divider on operand magnitudes.
    always_comb begin
        prod_s = {{32{E_A[31]}}, E_A} * {{32{E_B[31]}}, E_B};
        prod_u = {32'd0, E_A} * {32'd0, E_B};
        sdiv   = (E_MDOp == OP_DIV);
        neg_a  = sdiv & E_A[31];
        neg_b  = sdiv & E_B[31];
        div_n  = neg_a ? (32'd0 - E_A) : E_A;
        div_d  = neg_b ? (32'd0 - E_B) : E_B;
        // Divisor forced to 1 on zero so the divider never sees 0; result is discarded anyway.
        if (E_B == '0) begin
            div_d = 32'd1;
        end
        uq  = div_n / div_d;
        ur  = div_n % div_d;
        quo = (neg_a ^ neg_b) ? (32'd0 - uq) : uq;
        rem = neg_a ? (32'd0 - ur) : ur;
    end

    // Next-state: issue in IDLE, count down in BUSY, commit on the 1->0 step.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        phi_d   = phi_q;
        plo_d   = plo_q;
        pval_d  = pval_q;
        unique case (state_q)
            IDLE: begin
                if (E_Start) begin
                    case (E_MDOp)
                        OP_MULT, OP_MULTU: begin
                            {phi_d, plo_d} = (E_MDOp == OP_MULT) ? prod_s : prod_u;
                            pval_d  = 1'b1;
                            cnt_d   = MULT_LOAD;
                            state_d = BUSY;
                        end
                        OP_DIV, OP_DIVU: begin
                            phi_d   = rem;
                            plo_d   = quo;
                            pval_d  = (E_B != '0);
                            cnt_d   = DIV_LOAD;
                            state_d = BUSY;
                        end
                        OP_MTHI: hi_d = E_A;
                        OP_MTLO: lo_d = E_A;
                        default: ;
                    endcase
                end
            end
            BUSY: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = IDLE;
                    pval_d  = 1'b0;
                    if (pval_q) begin
                        hi_d = phi_q;
                        lo_d = plo_q;
                    end
                end
            end
        endcase
    end

    // State and architectural registers; reset clears everything at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            phi_q   <= '0;
            plo_q   <= '0;
            pval_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            phi_q   <= phi_d;
            plo_q   <= plo_d;
            pval_q  <= pval_d;
        end
    end

    // Outputs: the issue term is gated by reset so busy drops as soon as reset asserts.
    always_comb begin
        is_md_op   = (E_MDOp == OP_MULT) | (E_MDOp == OP_MULTU) |
                     (E_MDOp == OP_DIV)  | (E_MDOp == OP_DIVU);
        E_HILObusy = (state_q == BUSY) | (reset & E_Start & is_md_op);
        E_MDOut    = E_MFSel ? hi_q : lo_q;
        HI         = hi_q;
        LO         = lo_q;
    end

endmodule

// File: tb/tb_hilo_md_ctrl.sv
// Testbench for hilo_md_ctrl: directed table, hand-written corner sequences,
// then random traffic against a cycle-indexed behavioural model.
module tb_hilo_md_ctrl;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  E_MDOp = '0;
    logic        E_Start = 1'b0;
    logic [31:0] E_A = '0;
    logic [31:0] E_B = '0;
    logic        E_MFSel = 1'b0;
    logic [31:0] E_MDOut;
    logic        E_HILObusy;
    logic [31:0] HI;
    logic [31:0] LO;

    hilo_md_ctrl #(
        .MULT_CYCLES(MC),
        .DIV_CYCLES (DC)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .E_MDOp    (E_MDOp),
        .E_Start   (E_Start),
        .E_A       (E_A),
        .E_B       (E_B),
        .E_MFSel   (E_MFSel),
        .E_MDOut   (E_MDOut),
        .E_HILObusy(E_HILObusy),
        .HI        (HI),
        .LO        (LO)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          busy;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs[13];

    // Issue one op from idle, count busy cycles (bounded), then check HI/LO/read mux.
    task automatic run_row(input vec_t v, input int idx);
        int cnt;
        bit done;
        E_MDOp = v.op; E_A = v.a; E_B = v.b; E_Start = 1'b1;
        #4;
        cnt = E_HILObusy ? 1 : 0;
        @(posedge clk); #1;
        E_Start = 1'b0; E_MDOp = '0;
        done = 1'b0;
        for (int k = 0; k < 40; k++) begin
            #4;
            if (!E_HILObusy) begin
                done = 1'b1;
                break;
            end
            cnt++;
            @(posedge clk); #1;
        end
        chk($sformatf("row%0d_busy_ends", idx), 32'(done), 32'd1);
        chk($sformatf("row%0d_busy_cycles", idx), 32'(cnt), 32'(v.busy));
        chk($sformatf("row%0d_HI", idx), HI, v.hi);
        chk($sformatf("row%0d_LO", idx), LO, v.lo);
        E_MFSel = 1'b1; #1;
        chk($sformatf("row%0d_MDOut_hi", idx), E_MDOut, v.hi);
        E_MFSel = 1'b0; #1;
        chk($sformatf("row%0d_MDOut_lo", idx), E_MDOut, v.lo);
        @(posedge clk); #1;
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        E_MDOp = op; E_A = a; E_B = b; E_Start = 1'b1;
        @(posedge clk); #1;
        E_Start = 1'b0; E_MDOp = '0;
    endtask

    // Behavioural model: commit scheduled at an absolute cycle index.
    logic [31:0] m_hi, m_lo, mp_hi, mp_lo;
    bit          mp_v;
    int          cyc, commit_cyc;

    function automatic bit model_busy_reg();
        return (commit_cyc >= cyc);
    endfunction

    task automatic model_reset();
        m_hi = '0; m_lo = '0; mp_hi = '0; mp_lo = '0; mp_v = 1'b0;
        cyc = 0; commit_cyc = -1;
    endtask

    task automatic model_edge();
        longint          x, y, q, r;
        longint unsigned ux, uy, uq, ur;
        logic [63:0]     p;
        if (model_busy_reg()) begin
            if (commit_cyc == cyc) begin
                if (mp_v) begin
                    m_hi = mp_hi;
                    m_lo = mp_lo;
                end
                commit_cyc = -1;
            end
        end else if (E_Start) begin
            case (E_MDOp)
                3'd1: begin
                    x = $signed(E_A); y = $signed(E_B);
                    p = 64'(x * y);
                    {mp_hi, mp_lo} = p; mp_v = 1'b1; commit_cyc = cyc + MC;
                end
                3'd2: begin
                    ux = E_A; uy = E_B;
                    p = 64'(ux * uy);
                    {mp_hi, mp_lo} = p; mp_v = 1'b1; commit_cyc = cyc + MC;
                end
                3'd3, 3'd4: begin
                    if (E_B == 32'd0) begin
                        mp_v = 1'b0;
                    end else if (E_MDOp == 3'd3) begin
                        x = $signed(E_A); y = $signed(E_B);
                        q = x / y; r = x % y;
                        mp_lo = q[31:0]; mp_hi = r[31:0]; mp_v = 1'b1;
                    end else begin
                        ux = E_A; uy = E_B;
                        uq = ux / uy; ur = ux % uy;
                        mp_lo = uq[31:0]; mp_hi = ur[31:0]; mp_v = 1'b1;
                    end
                    commit_cyc = cyc + DC;
                end
                3'd5: m_hi = E_A;
                3'd6: m_lo = E_A;
                default: ;
            endcase
        end
        cyc++;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic exp_busy;
        logic [31:0] exp_out;

        vecs[0]  = '{3'd1, 32'hFFFF_FFFF, 32'd2,          MC + 1, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
        vecs[1]  = '{3'd2, 32'hFFFF_FFFF, 32'd2,          MC + 1, 32'h0000_0001, 32'hFFFF_FFFE};
        vecs[2]  = '{3'd3, 32'hFFFF_FFF9, 32'd2,          DC + 1, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[3]  = '{3'd4, 32'd7,         32'd2,          DC + 1, 32'h0000_0001, 32'h0000_0003};
        vecs[4]  = '{3'd3, 32'h8000_0000, 32'hFFFF_FFFF,  DC + 1, 32'h0000_0000, 32'h8000_0000};
        vecs[5]  = '{3'd5, 32'h0000_1234, 32'd0,          0,      32'h0000_1234, 32'h8000_0000};
        vecs[6]  = '{3'd6, 32'h0000_5678, 32'd0,          0,      32'h0000_1234, 32'h0000_5678};
        vecs[7]  = '{3'd3, 32'h0000_0064, 32'd0,          DC + 1, 32'h0000_1234, 32'h0000_5678};
        vecs[8]  = '{3'd7, 32'hDEAD_BEEF, 32'd3,          0,      32'h0000_1234, 32'h0000_5678};
        vecs[9]  = '{3'd3, 32'd7,         32'hFFFF_FFFE,  DC + 1, 32'h0000_0001, 32'hFFFF_FFFD};
        vecs[10] = '{3'd1, 32'h0001_0000, 32'h0001_0000,  MC + 1, 32'h0000_0001, 32'h0000_0000};
        vecs[11] = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF,  MC + 1, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[12] = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF,  MC + 1, 32'h0000_0000, 32'h0000_0001};

        // Reset state
        #1 reset = 1'b0;
        #1;
        chk("rst_busy", 32'(E_HILObusy), 32'd0);
        chk("rst_HI", HI, 32'd0);
        chk("rst_LO", LO, 32'd0);
        chk("rst_MDOut", E_MDOut, 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;

        // Directed table
        for (int i = 0; i < 13; i++) begin
            run_row(vecs[i], i);
        end

        // Async reset in the middle of a multiply
        issue(3'd5, 32'h55, 32'd0);
        issue(3'd6, 32'h66, 32'd0);
        issue(3'd1, 32'd3, 32'd4);          // now in cycle t+1
        @(posedge clk); #1;                 // cycle t+2
        chk("midrst_busy_before", 32'(E_HILObusy), 32'd1);
        reset = 1'b0;
        #1;
        chk("midrst_busy", 32'(E_HILObusy), 32'd0);
        chk("midrst_HI", HI, 32'd0);
        chk("midrst_LO", LO, 32'd0);
        chk("midrst_MDOut", E_MDOut, 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        issue(3'd5, 32'hAB, 32'd0);         // first start after release
        #3;
        chk("postrst_mthi", HI, 32'h0000_00AB);
        repeat (DC) @(posedge clk);
        #1;
        chk("postrst_no_commit_LO", LO, 32'd0);
        chk("postrst_idle", 32'(E_HILObusy), 32'd0);

        // Start held high while busy must be ignored
        issue(3'd6, 32'h77, 32'd0);
        E_MDOp = 3'd1; E_A = 32'd3; E_B = 32'd4; E_Start = 1'b1;
        #3;
        chk("hold_busy_t", 32'(E_HILObusy), 32'd1);
        for (int k = 1; k <= MC; k++) begin
            @(posedge clk); #1;
            E_MDOp = (k % 2 == 1) ? 3'd5 : 3'd3;
            E_A = 32'hDEAD_0000 + 32'(k);
            E_B = (k % 2 == 1) ? 32'd1 : 32'd0;
            #3;
            chk($sformatf("hold_busy_t%0d", k), 32'(E_HILObusy), 32'd1);
        end
        chk("hold_commit_cycle_old_LO", E_MDOut, 32'h0000_0077);
        chk("hold_commit_cycle_old_HI", HI, 32'h0000_00AB);
        @(posedge clk); #1;
        E_Start = 1'b0; E_MDOp = '0;
        #3;
        chk("hold_done_busy", 32'(E_HILObusy), 32'd0);
        chk("hold_HI", HI, 32'd0);
        chk("hold_LO", LO, 32'd12);

        // Random traffic against the model
        reset = 1'b0;
        #2;
        reset = 1'b1;
        model_reset();
        @(posedge clk); #1;
        for (int i = 0; i < 800; i++) begin
            E_Start = ($urandom_range(0, 9) < 4);
            E_MDOp  = 3'($urandom_range(0, 7));
            E_A     = pick();
            E_B     = pick();
            E_MFSel = 1'($urandom_range(0, 1));
            #4;
            exp_busy = model_busy_reg() || (E_Start && (E_MDOp inside {[3'd1:3'd4]}));
            exp_out  = E_MFSel ? m_hi : m_lo;
            chk($sformatf("rnd%0d_busy", i), 32'(E_HILObusy), 32'(exp_busy));
            chk($sformatf("rnd%0d_MDOut", i), E_MDOut, exp_out);
            chk($sformatf("rnd%0d_HI", i), HI, m_hi);
            chk($sformatf("rnd%0d_LO", i), LO, m_lo);
            @(posedge clk);
            model_edge();
            #1;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/hilo_md_ctrl.md
# hilo_md_ctrl

Multiply/divide sequencer and HI/LO register owner for the E stage of the five-stage pipeline. It accepts one mult/div/mthi/mtlo operation per issue, models the multi-cycle latency of the multiplier and divider with a down-counter, and commits results to HI/LO. It drives `E_HILObusy` to the hazard unit, which stalls any HI/LO-class instruction in D while an operation is starting or in flight.

## Interface
Parameters:
- `MULT_CYCLES`, 5: busy cycles for mult/multu (1..15).
- `DIV_CYCLES`, 10: busy cycles for div/divu (1..15).

Ports:
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-low. Clears all state immediately.
- `E_MDOp`  in  3  operation code: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo. Codes 7 and up are treated as none.
- `E_Start`  in  1  issue strobe; qualifies `E_MDOp` for one cycle.
- `E_A`  in  32  rs operand, already forwarded.
- `E_B`  in  32  rt operand, already forwarded.
- `E_MFSel`  in  1  read select: 1 returns HI, 0 returns LO.
- `E_MDOut`  out  32  combinational HI or LO, chosen by `E_MFSel`.
- `E_HILObusy`  out  1  `E_Start & (op is 1..4)` OR busy state.
- `HI`, `LO`  out  32  architectural registers.

## Operation
- States:
  - IDLE: the counter is 0.
  - BUSY: the counter is nonzero.
- Reset values: state IDLE, counter 0, HI 0, LO 0, pending regs 0, `E_HILObusy` 0, `E_MDOut` 0.
- IDLE + `E_Start` + op 1/2:
  - The signed (1) or unsigned (2) 64-bit product is latched into the pending regs.
  - The counter loads `MULT_CYCLES`; go to BUSY.
- IDLE + `E_Start` + op 3/4:
  - The signed (3) or unsigned (4) quotient goes to pending LO and the remainder to pending HI.
  - Signed division truncates toward zero; the remainder takes the sign of the dividend.
  - The counter loads `DIV_CYCLES`; go to BUSY.
- Divide by zero (`E_B==0`): the busy timing is the same as a normal divide. The commit is suppressed, so HI/LO are unchanged. A pending-valid flag is cleared for this case.
- IDLE + `E_Start` + op 5/6: HI (5) or LO (6) ← `E_A` at the same edge. No busy cycles.
- BUSY:
  - The counter decrements each edge.
  - On the edge where the counter goes 1→0, the pending regs are written to HI/LO (if pending-valid) and the state returns to IDLE.
- `E_Start` while BUSY, any op: ignored. The hazard unit guarantees this does not happen; it is not an error condition.
- Signed `div` of 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0. This is the result of 32-bit wrap; no trap is raised.
- `E_MDOut` reflects HI/LO as they were committed before the current edge. A commit edge and a read in the same cycle return the old value.

## Timing
- Start is sampled at edge E0, the end of cycle t.
- `E_HILObusy` timing:
  - High combinationally during cycle t.
  - High as registered busy during cycles t+1 .. t+N, where N = `MULT_CYCLES` or `DIV_CYCLES`.
- HI/LO are updated at the edge ending cycle t+N and are visible from cycle t+N+1.
- An instruction stalled in D on `E_HILObusy` can issue at the earliest in cycle t+N+1 and reads the new values.
- mthi/mtlo: `E_HILObusy` is never asserted; the new value is visible in cycle t+1.
- Back-to-back operations: a second start is accepted in cycle t+N+1. There is no dead cycle.
- Reset asserted mid-BUSY:
  - Counter, HI and LO clear immediately; `E_HILObusy` drops without waiting for a clock.
  - The pending result is discarded.
  - The first start after reset deassertion is accepted on the next edge.

## Test plan
- After reset, issue `mult` with A=0xFFFFFFFF, B=2:
  - `E_HILObusy` stays high for cycles t..t+5.
  - In cycle t+6, HI=0xFFFFFFFF and LO=0xFFFFFFFE.
- `multu` with the same operands → HI=0x00000001, LO=0xFFFFFFFE after 5 busy cycles.
- `div` with A=0xFFFFFFF9 (-7), B=2:
  - `E_HILObusy` is high for exactly 11 cycles (t..t+10).
  - LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- `divu` with A=7, B=2 → LO=3, HI=1.
- Divide by zero:
  - Preload HI=0x1234 with `mthi` and LO=0x5678 with `mtlo`.
  - Issue `div` with B=0.
  - Required: 10 busy cycles, then HI/LO still 0x1234/0x5678.
  - Check `E_MDOut` with both `E_MFSel` values.
- Reset during operation:
  - Start `mult` with A=3, B=4, and pulse `reset` low in cycle t+2.
  - Required: busy, HI and LO read 0 immediately.
  - Keep `E_Start` held high while BUSY in a separate run and check that the start is ignored and the result is unchanged.
